led_debug_reader: RTL and testbench
===================================

Name: led_debug_reader

Overview:
- Board-side reader for the CPU debug/observation path. It sits between Top's debug port and the 4 board LEDs.
- Each frame it samples SW to choose a 32-bit debug source, requests that word from the core with a req/valid handshake, then shows it on LED one nibble at a time, MSB nibble first.
- It is the consuming end of the SW-in / LED-out interface that board-level benches drive and observe.

Parameters:
- TICK_CYCLES, 25000000, CLOCK_IN cycles each nibble stays on LED (must be >=2).
- TIMEOUT, 255, cycles to wait for DBG_VALID before declaring an error (must be >=1).
- ERR_WORD, 32'hDEADBEEF, word displayed when the handshake times out.

Ports:
- CLOCK_IN  in  1  system clock; all logic on the rising edge.
- RESET  in  1  asynchronous, active-low reset.
- SW  in  3  debug source select; sampled only at frame start.
- DBG_REQ  out  1  request to the core debug port.
- DBG_SEL  out  3  source index presented with DBG_REQ.
- DBG_VALID  in  1  core asserts for one or more cycles when DBG_DATA is valid.
- DBG_DATA  in  32  debug word.
- LED  out  4  current nibble.
- FRAME_START  out  1  one-cycle pulse at the start of each frame.
- ERR  out  1  high while a timed-out frame is being displayed.

Behaviour:
- Reset (RESET=0, asynchronous):
  - State=IDLE; DBG_REQ=0, DBG_SEL=0, LED=0, FRAME_START=0, ERR=0.
  - Tick counter, nibble index and timeout counter all 0.
  - Reset asserted mid-frame aborts the frame at once; no partial state survives.
- States: IDLE, REQ, SHOW, plus GAP when the optional feature is compiled in.
- IDLE: on the first edge after reset release, or on frame end:
  - FRAME_START=1 for one cycle.
  - DBG_SEL<=SW, DBG_REQ<=1, timeout counter<=0.
  - Go to REQ.
- REQ:
  - DBG_REQ and DBG_SEL are held stable.
  - On an edge where DBG_VALID=1: capture DBG_DATA into the shadow register, ERR<=0, DBG_REQ<=0, go to SHOW.
  - Otherwise increment the timeout counter. When it reaches TIMEOUT with no valid, load shadow<=ERR_WORD, ERR<=1, DBG_REQ<=0, go to SHOW.
  - DBG_VALID on the same edge as the timeout wins: data is captured and ERR=0.
- SHOW:
  - Nibble index starts at 7. LED=shadow[4*idx+3 : 4*idx], registered; the first nibble appears on the edge that enters SHOW.
  - The tick counter counts 0..TICK_CYCLES-1. At wrap, idx decrements.
  - After idx 0 has been shown for TICK_CYCLES cycles, go to IDLE (or GAP when enabled).
- Frame length:
  - The REQ exit edge is counted as the first SHOW cycle.
  - Each frame = 1 IDLE cycle + REQ cycles + 8*TICK_CYCLES SHOW cycles.
- Input and output rules:
  - DBG_VALID outside REQ is ignored.
  - SW changes outside the IDLE sample cycle do not affect the current frame.
  - DBG_DATA is only sampled in REQ.
  - LED keeps its last value through IDLE and REQ; it changes only in SHOW (or GAP).
  - ERR stays at its value until the next capture.
- Counter widths: sized with $clog2 of TICK_CYCLES and of TIMEOUT+1. There is no overflow; counters clear on state entry.

Optional Feature:
- Macro: LED_FRAME_GAP_EN.
- Defined: after nibble 0, enter GAP for TICK_CYCLES cycles with LED=4'b0000, then go to IDLE. This gives a visible separator between words.
- Undefined: the GAP state and its logic are absent; SHOW goes directly to IDLE.

Test Plan:
- Parameters for all scenarios: TICK_CYCLES=4, TIMEOUT=8.
- Reset: hold RESET=0 for 6 cycles with SW=3'b001 -> all outputs 0. Release -> FRAME_START pulses on the first edge, then DBG_REQ=1 with DBG_SEL=3'b001.
- Normal read: DBG_VALID=1 with DBG_DATA=32'h1234ABCD on the 3rd REQ cycle -> DBG_REQ drops on the same edge. LED shows 1,2,3,4,A,B,C,D, each held 4 cycles. The next FRAME_START comes 1 cycle after D ends. ERR=0.
- Timeout: keep DBG_VALID=0 -> after 8 REQ cycles DBG_REQ=0 and ERR=1. LED shows D,E,A,D,B,E,E,F. The next frame restarts REQ.
- Select latching: SW=3'b010 at frame start, change to 3'b111 during SHOW -> DBG_SEL stays 3'b010 for this frame and is 3'b111 in the next frame's REQ.
- Mid-frame reset: drive RESET=0 between edges while LED=4'hA -> LED=0, DBG_REQ=0, ERR=0 immediately, without waiting for a clock edge.
- Gap (LED_FRAME_GAP_EN defined): after nibble D, LED=0 for 4 cycles, then FRAME_START. Undefined: FRAME_START comes 1 cycle after D.

Source files
------------

// File: rtl/led_debug_reader_if.sv
// led_debug_reader_if: SW-in / LED-out board bus between the debug reader and core/board side.
interface led_debug_reader_if;
  logic [2:0]  SW;
  logic        DBG_REQ;
  logic [2:0]  DBG_SEL;
  logic        DBG_VALID;
  logic [31:0] DBG_DATA;
  logic [3:0]  LED;
  logic        FRAME_START;
  logic        ERR;
  modport master (
    input  SW, DBG_VALID, DBG_DATA,
    output DBG_REQ, DBG_SEL, LED, FRAME_START, ERR
  );
  modport slave (
    output SW, DBG_VALID, DBG_DATA,
    input  DBG_REQ, DBG_SEL, LED, FRAME_START, ERR
  );
endinterface

// File: rtl/led_debug_reader.sv
// led_debug_reader: fetches a 32-bit debug word per frame and shows it on LED nibble by nibble, MSB first.
// Define LED_FRAME_GAP_EN to insert a blank (LED=0) separator of TICK_CYCLES cycles after each word.
module led_debug_reader #(
  parameter int          TICK_CYCLES = 25000000,
  parameter int          TIMEOUT     = 255,
  parameter logic [31:0] ERR_WORD    = 32'hDEADBEEF
) (
  input logic               CLOCK_IN,
  input logic               RESET,
  led_debug_reader_if.master bus
);
  localparam int TW = $clog2(TICK_CYCLES);
  localparam int OW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_CYCLES - 1);
  localparam logic [OW-1:0] TMO_LAST  = OW'(TIMEOUT - 1);
  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] REQ  = 2'd1;
  localparam logic [1:0] SHOW = 2'd2;
`ifdef LED_FRAME_GAP_EN
  localparam logic [1:0] GAP  = 2'd3;
`endif
  logic [1:0]    state;
  logic [TW-1:0] tick;
  logic [OW-1:0] tmo;
  logic [2:0]    idx;
  logic [31:0]   shadow;
  logic [31:0]   word;
  logic          req;
  logic [2:0]    sel;
  logic [3:0]    led;
  logic          frame_start;
  logic          err;
  // valid on the timeout edge still wins, so the fallback word is chosen only without valid
  assign word = bus.DBG_VALID ? bus.DBG_DATA : ERR_WORD;
  always_ff @(posedge CLOCK_IN or negedge RESET)
    if (!RESET) begin
      state       <= IDLE;
      tick        <= '0;
      tmo         <= '0;
      idx         <= '0;
      shadow      <= '0;
      req         <= 1'b0;
      sel         <= '0;
      led         <= '0;
      frame_start <= 1'b0;
      err         <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      case (state)
        IDLE: begin
          frame_start <= 1'b1;
          sel         <= bus.SW;
          req         <= 1'b1;
          tmo         <= '0;
          state       <= REQ;
        end
        REQ:
          if (bus.DBG_VALID || tmo == TMO_LAST) begin
            shadow <= word;
            led    <= word[31:28];
            err    <= !bus.DBG_VALID;
            req    <= 1'b0;
            idx    <= 3'd7;
            tick   <= '0;
            state  <= SHOW;
          end else
            tmo <= tmo + OW'(1);
        SHOW:
          if (tick == TICK_LAST) begin
            tick <= '0;
            if (idx == 3'd0) begin
`ifdef LED_FRAME_GAP_EN
              led   <= 4'h0;
              state <= GAP;
`else
              state <= IDLE;
`endif
            end else begin
              idx <= idx - 3'd1;
              led <= shadow[{idx - 3'd1, 2'b00} +: 4];
            end
          end else
            tick <= tick + TW'(1);
`ifdef LED_FRAME_GAP_EN
        GAP:
          if (tick == TICK_LAST) begin
            tick  <= '0;
            state <= IDLE;
          end else
            tick <= tick + TW'(1);
`endif
        default: state <= IDLE;
      endcase
    end
  assign bus.DBG_REQ     = req;
  assign bus.DBG_SEL     = sel;
  assign bus.LED         = led;
  assign bus.FRAME_START = frame_start;
  assign bus.ERR         = err;
endmodule

// File: tb/tb_led_debug_reader.sv
// tb_led_debug_reader: scoreboard bench for led_debug_reader with TICK_CYCLES=4, TIMEOUT=8.
module tb_led_debug_reader;
`ifdef LED_FRAME_GAP_EN
  localparam int GAP = 4;
`else
  localparam int GAP = 0;
`endif
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int n_cmp = 0;
  int n_err = 0;
  logic [3:0] q[$];
  led_debug_reader_if bus();
  led_debug_reader #(.TICK_CYCLES(4), .TIMEOUT(8), .ERR_WORD(32'hDEADBEEF)) dut (
    .CLOCK_IN(clk),
    .RESET(rst_n),
    .bus(bus)
  );
  always #5 clk = ~clk;

  task automatic push_word(input logic [31:0] w);
    for (int k = 7; k >= 0; k--) q.push_back(w[4*k +: 4]);
  endtask

  task automatic test_reset;
    bus.SW = 3'b001;
    bus.DBG_VALID = 1'b0;
    bus.DBG_DATA = '0;
    repeat (6) @(negedge clk);
    n_cmp++;
    if ({bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL, bus.LED, bus.ERR} !== 10'b0) begin
      n_err++;
      $display("FAIL reset_hold: got fs/req/sel/led/err=%b want 0", {bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL, bus.LED, bus.ERR});
    end
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL, bus.LED, bus.ERR} !== {1'b1, 1'b1, 3'b001, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL reset_release: got fs/req/sel/led/err=%b want 1_1_001_0000_0", {bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL, bus.LED, bus.ERR});
    end
  endtask

  task automatic test_normal;
    logic [3:0] e = '0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus.DBG_REQ !== 1'b1) begin
      n_err++;
      $display("FAIL normal_req_held: got %b want 1", bus.DBG_REQ);
    end
    bus.DBG_VALID = 1'b1;
    bus.DBG_DATA = 32'h1234ABCD;
    push_word(32'h1234ABCD);
    // stray valid/data during SHOW must not disturb the displayed word
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.DBG_VALID = (i < 28);
      bus.DBG_DATA = $urandom;
      if (i % 4 == 0) e = q.pop_front();
      n_cmp++;
      if ({bus.LED, bus.DBG_REQ, bus.ERR, bus.FRAME_START} !== {e, 3'b000}) begin
        n_err++;
        $display("FAIL normal_show[%0d]: got led/req/err/fs=%h/%b%b%b want %h/000", i, bus.LED, bus.DBG_REQ, bus.ERR, bus.FRAME_START, e);
      end
    end
    for (int i = 0; i <= GAP; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.FRAME_START, bus.LED} !== {1'b0, (GAP != 0) ? 4'h0 : 4'hD}) begin
        n_err++;
        $display("FAIL normal_frame_end[%0d]: got fs=%b led=%h", i, bus.FRAME_START, bus.LED);
      end
    end
    @(negedge clk);
    n_cmp++;
    if ({bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL} !== {1'b1, 1'b1, 3'b001}) begin
      n_err++;
      $display("FAIL normal_next_frame: got fs/req/sel=%b want 1_1_001", {bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL});
    end
  endtask

  task automatic test_timeout;
    logic [3:0] e = '0;
    bus.DBG_VALID = 1'b0;
    push_word(32'hDEADBEEF);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      n_cmp++;
      if ({bus.DBG_REQ, bus.ERR} !== 2'b10) begin
        n_err++;
        $display("FAIL timeout_wait[%0d]: got req/err=%b want 10", i, {bus.DBG_REQ, bus.ERR});
      end
    end
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      if (i % 4 == 0) e = q.pop_front();
      n_cmp++;
      if ({bus.LED, bus.DBG_REQ, bus.ERR} !== {e, 2'b01}) begin
        n_err++;
        $display("FAIL timeout_show[%0d]: got led/req/err=%h/%b%b want %h/01", i, bus.LED, bus.DBG_REQ, bus.ERR, e);
      end
    end
    repeat (GAP + 1) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.FRAME_START, bus.DBG_REQ, bus.ERR} !== 3'b111) begin
      n_err++;
      $display("FAIL timeout_restart: got fs/req/err=%b want 111", {bus.FRAME_START, bus.DBG_REQ, bus.ERR});
    end
  endtask

  task automatic test_select;
    logic [3:0] e = '0;
    logic [31:0] w;
    bus.SW = 3'b010;
    bus.DBG_VALID = 1'b1;
    bus.DBG_DATA = $urandom;
    @(negedge clk);
    bus.DBG_VALID = 1'b0;
    n_cmp++;
    if ({bus.ERR, bus.DBG_REQ} !== 2'b00) begin
      n_err++;
      $display("FAIL select_first_capture: got err/req=%b want 00", {bus.ERR, bus.DBG_REQ});
    end
    repeat (31 + GAP + 1) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.FRAME_START, bus.DBG_SEL} !== {1'b1, 3'b010}) begin
      n_err++;
      $display("FAIL select_latch: got fs/sel=%b want 1_010", {bus.FRAME_START, bus.DBG_SEL});
    end
    w = $urandom;
    bus.DBG_VALID = 1'b1;
    bus.DBG_DATA = w;
    push_word(w);
    for (int i = 0; i < 32; i++) begin
      @(negedge clk);
      bus.DBG_VALID = 1'b0;
      bus.SW = 3'b111;
      if (i % 4 == 0) e = q.pop_front();
      n_cmp++;
      if ({bus.LED, bus.DBG_SEL} !== {e, 3'b010}) begin
        n_err++;
        $display("FAIL select_show[%0d]: got led/sel=%h/%b want %h/010", i, bus.LED, bus.DBG_SEL, e);
      end
    end
    repeat (GAP + 1) @(negedge clk);
    @(negedge clk);
    n_cmp++;
    if ({bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL} !== {1'b1, 1'b1, 3'b111}) begin
      n_err++;
      $display("FAIL select_next_frame: got fs/req/sel=%b want 1_1_111", {bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL});
    end
  endtask

  task automatic test_mid_reset;
    bus.DBG_VALID = 1'b0;
    repeat (16) @(negedge clk);
    n_cmp++;
    if ({bus.LED, bus.ERR} !== {4'hA, 1'b1}) begin
      n_err++;
      $display("FAIL midreset_pre: got led/err=%h/%b want a/1", bus.LED, bus.ERR);
    end
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({bus.LED, bus.DBG_REQ, bus.ERR, bus.FRAME_START, bus.DBG_SEL} !== 10'b0) begin
      n_err++;
      $display("FAIL midreset_async: got led/req/err/fs/sel=%b want 0", {bus.LED, bus.DBG_REQ, bus.ERR, bus.FRAME_START, bus.DBG_SEL});
    end
    @(negedge clk);
    bus.SW = 3'b101;
    rst_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL, bus.LED, bus.ERR} !== {1'b1, 1'b1, 3'b101, 4'h0, 1'b0}) begin
      n_err++;
      $display("FAIL midreset_restart: got fs/req/sel/led/err=%b want 1_1_101_0000_0", {bus.FRAME_START, bus.DBG_REQ, bus.DBG_SEL, bus.LED, bus.ERR});
    end
  endtask

  initial begin
    test_reset();
    test_normal();
    test_timeout();
    test_select();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
